// File: rtl/xnor_score_pkg.sv
// xnor_score_pkg: width helpers and saturating increment shared by the match scorer
package xnor_score_pkg;

    function automatic int clog2(input int n);
        int r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) r++;
        return r;
    endfunction

    function automatic int score_w(input int width);
        return clog2(width + 1);
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
        return (v == (32'd1 << w) - 32'd1) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/xnor_match_scorer_if.sv
// xnor_match_scorer_if: input word handshake, clear and scored result beat
interface xnor_match_scorer_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    localparam int SCORE_W = xnor_score_pkg::score_w(WIDTH);

    logic [WIDTH-1:0]   eq_bits;
    logic               in_valid;
    logic               in_ready;
    logic               clear;
    logic               out_valid;
    logic               out_ready;
    logic [SCORE_W-1:0] score;
    logic               hit;
    logic [CNT_W-1:0]   streak;
    logic [CNT_W-1:0]   total;

    modport master (
        output eq_bits, in_valid, clear, out_ready,
        input  in_ready, out_valid, score, hit, streak, total
    );

    modport slave (
        input  eq_bits, in_valid, clear, out_ready,
        output in_ready, out_valid, score, hit, streak, total
    );

endinterface

// File: rtl/bit_popcount.sv
// bit_popcount: combinational adder tree counting the ones in a word
module bit_popcount
    import xnor_score_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]          bits,
    output logic [score_w(WIDTH)-1:0] count
);
    localparam int SCORE_W = score_w(WIDTH);

    if (WIDTH == 1) begin : g_leaf
        assign count = bits;
    end else begin : g_node
        localparam int LO = WIDTH / 2;
        localparam int HI = WIDTH - LO;
        logic [score_w(LO)-1:0] lo_c;
        logic [score_w(HI)-1:0] hi_c;
        bit_popcount #(.WIDTH(LO)) u_lo (.bits(bits[LO-1:0]),     .count(lo_c));
        bit_popcount #(.WIDTH(HI)) u_hi (.bits(bits[WIDTH-1:LO]), .count(hi_c));
        assign count = SCORE_W'(lo_c) + SCORE_W'(hi_c);
    end

endmodule

// File: rtl/xnor_match_scorer.sv
// xnor_match_scorer: two-stage scorer of XNOR match words with saturating hit streak/total counters
module xnor_match_scorer
    import xnor_score_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int THRESH = WIDTH,
    parameter int CNT_W  = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    xnor_match_scorer_if.slave  bus
);
    localparam int SCORE_W = score_w(WIDTH);

    logic [WIDTH-1:0]   s1_q;
    logic               s1_v, out_v, hit_q, hit_d, s2_free, xfer, accept;
    logic [SCORE_W-1:0] pc, score_q;
    logic [CNT_W-1:0]   str_q, tot_q, str_b, tot_b, str_d, tot_d, streak_q, total_q;

    assign s2_free      = !out_v || bus.out_ready;
    assign xfer         = s1_v && s2_free;
    assign bus.in_ready = rst_n && (!s1_v || s2_free);
    assign accept       = bus.in_valid && bus.in_ready;

    assign bus.out_valid = out_v;
    assign bus.score     = score_q;
    assign bus.hit       = hit_q;
    assign bus.streak    = streak_q;
    assign bus.total     = total_q;

    bit_popcount #(.WIDTH(WIDTH)) u_popcount (.bits(s1_q), .count(pc));

    // next counter values for the beat in S1; a same-cycle clear restarts from zero
    always_comb begin
        hit_d = int'(pc) >= THRESH;
        str_b = bus.clear ? '0 : str_q;
        tot_b = bus.clear ? '0 : tot_q;
        str_d = hit_d ? CNT_W'(sat_inc(32'(str_b), CNT_W)) : '0;
        tot_d = hit_d ? CNT_W'(sat_inc(32'(tot_b), CNT_W)) : tot_b;
    end

    // S1 capture, S1->S2 transfer with counter update, and output consume
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q     <= '0;
            s1_v     <= 1'b0;
            out_v    <= 1'b0;
            score_q  <= '0;
            hit_q    <= 1'b0;
            streak_q <= '0;
            total_q  <= '0;
            str_q    <= '0;
            tot_q    <= '0;
        end else begin
            if (accept) s1_q <= bus.eq_bits;
            s1_v <= accept || (s1_v && !xfer);
            if (xfer) begin
                out_v    <= 1'b1;
                score_q  <= pc;
                hit_q    <= hit_d;
                streak_q <= str_d;
                total_q  <= tot_d;
                str_q    <= str_d;
                tot_q    <= tot_d;
            end else begin
                if (bus.out_ready) out_v <= 1'b0;
                if (bus.clear) begin
                    str_q <= '0;
                    tot_q <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_xnor_match_scorer.sv
// tb_xnor_match_scorer: randomized and directed checks of three scorer configurations against a queue model
module tb_xnor_match_scorer;

    typedef struct packed {
        logic [3:0] s;
        logic       h;
        logic [7:0] st;
        logic [7:0] tt;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] ib [3];
    logic       iv [3];
    logic       ordy [3];
    logic       clr [3];
    logic       ir [3];
    logic       ov [3];
    logic       oh [3];
    logic [3:0] os [3];
    logic [7:0] ost [3];
    logic [7:0] otot [3];

    int thr [3] = '{8, 8, 5};
    int cap [3] = '{255, 15, 255};
    int m_str [3] = '{0, 0, 0};
    int m_tot [3] = '{0, 0, 0};

    int n_checks = 0;
    int n_err = 0;
    logic last_hit, prev_hit;
    logic [7:0] last_str, last_tot, peak_str;

    xnor_match_scorer_if #(.WIDTH(8), .CNT_W(8)) b0 ();
    xnor_match_scorer_if #(.WIDTH(8), .CNT_W(4)) b1 ();
    xnor_match_scorer_if #(.WIDTH(8), .CNT_W(8)) b2 ();

    xnor_match_scorer #(.WIDTH(8), .THRESH(8), .CNT_W(8)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    xnor_match_scorer #(.WIDTH(8), .THRESH(8), .CNT_W(4)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    xnor_match_scorer #(.WIDTH(8), .THRESH(5), .CNT_W(8)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));

    assign b0.eq_bits = ib[0];
    assign b0.in_valid = iv[0];
    assign b0.out_ready = ordy[0];
    assign b0.clear = clr[0];
    assign b1.eq_bits = ib[1];
    assign b1.in_valid = iv[1];
    assign b1.out_ready = ordy[1];
    assign b1.clear = clr[1];
    assign b2.eq_bits = ib[2];
    assign b2.in_valid = iv[2];
    assign b2.out_ready = ordy[2];
    assign b2.clear = clr[2];

    assign ir[0] = b0.in_ready;
    assign ov[0] = b0.out_valid;
    assign oh[0] = b0.hit;
    assign os[0] = b0.score;
    assign ost[0] = b0.streak;
    assign otot[0] = b0.total;
    assign ir[1] = b1.in_ready;
    assign ov[1] = b1.out_valid;
    assign oh[1] = b1.hit;
    assign os[1] = b1.score;
    assign ost[1] = {4'b0, b1.streak};
    assign otot[1] = {4'b0, b1.total};
    assign ir[2] = b2.in_ready;
    assign ov[2] = b2.out_valid;
    assign oh[2] = b2.hit;
    assign os[2] = b2.score;
    assign ost[2] = b2.streak;
    assign otot[2] = b2.total;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_stream(input int k, input logic [7:0] w[$], input int stall, input bit rnd);
        beat_t eq[$];
        beat_t hb, cur, e;
        int acc[$];
        int idx = 0;
        int c = 0;
        int lat, s;
        bit held = 0;
        bit h;
        peak_str = 8'd0;
        while ((idx < w.size() || eq.size() > 0) && c < 500) begin
            ib[k] = idx < w.size() ? w[idx] : 8'h00;
            iv[k] = idx < w.size() && (!rnd || $urandom_range(3) != 0);
            ordy[k] = c >= stall && (!rnd || $urandom_range(2) != 0);
            #1;
            cur = '{os[k], oh[k], ost[k], otot[k]};
            if (held) begin
                n_checks++;
                if (cur !== hb) begin
                    n_err++;
                    $display("FAIL stall_stable dut%0d: got %h expected %h", k, cur, hb);
                end
            end
            held = ov[k] && !ordy[k];
            hb = cur;
            if (stall > 0 && !rnd && c == stall - 1) begin
                n_checks++;
                if (idx != 2 || ir[k] !== 1'b0) begin
                    n_err++;
                    $display("FAIL bp_fill dut%0d: got accepts=%0d in_ready=%b expected accepts=2 in_ready=0", k, idx, ir[k]);
                end
            end
            if (ov[k] && ordy[k]) begin
                n_checks++;
                if (eq.size() == 0) begin
                    n_err++;
                    $display("FAIL extra_beat dut%0d: got %h expected no beat", k, cur);
                end else begin
                    e = eq.pop_front();
                    lat = acc.pop_front();
                    if (cur !== e) begin
                        n_err++;
                        $display("FAIL beat dut%0d: got %h expected %h", k, cur, e);
                    end
                    if (stall == 0 && !rnd) begin
                        n_checks++;
                        if (c != lat + 2) begin
                            n_err++;
                            $display("FAIL latency dut%0d: got %0d expected %0d", k, c - lat, 2);
                        end
                    end
                    prev_hit = last_hit;
                    last_hit = oh[k];
                    last_str = ost[k];
                    last_tot = otot[k];
                    if (ost[k] > peak_str) peak_str = ost[k];
                end
            end
            if (iv[k] && ir[k]) begin
                s = $countones(w[idx]);
                h = s >= thr[k];
                m_str[k] = h ? (m_str[k] < cap[k] ? m_str[k] + 1 : cap[k]) : 0;
                m_tot[k] = (h && m_tot[k] < cap[k]) ? m_tot[k] + 1 : m_tot[k];
                eq.push_back('{4'(s), h, 8'(m_str[k]), 8'(m_tot[k])});
                acc.push_back(c);
                idx++;
            end
            tick;
            c++;
        end
        iv[k] = 1'b0;
        ordy[k] = 1'b1;
        #1;
        n_checks++;
        if (c >= 500 || ov[k] !== 1'b0) begin
            n_err++;
            $display("FAIL drain dut%0d: got cycles=%0d out_valid=%b pending=%0d expected drained", k, c, ov[k], eq.size());
        end
        tick;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            iv[k] = 1'b1;
            ib[k] = 8'hFF;
        end
        tick;
        tick;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (ov[k] !== 1'b0 || ir[k] !== 1'b0 || os[k] !== 4'd0 || oh[k] !== 1'b0 || ost[k] !== 8'd0 || otot[k] !== 8'd0) begin
                n_err++;
                $display("FAIL reset_state dut%0d: got v=%b r=%b s=%0d h=%b st=%0d tt=%0d expected all 0", k, ov[k], ir[k], os[k], oh[k], ost[k], otot[k]);
            end
        end
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) iv[k] = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (ir[k] !== 1'b1) begin
                n_err++;
                $display("FAIL reset_release dut%0d: got in_ready=%b expected 1", k, ir[k]);
            end
        end
        tick;
    endtask

    task automatic test_back_to_back;
        logic [7:0] w[$] = '{8'hFF, 8'hFF, 8'h7F, 8'hFF, 8'h00};
        run_stream(0, w, 0, 0);
        n_checks++;
        if (last_tot !== 8'd3 || last_str !== 8'd0) begin
            n_err++;
            $display("FAIL b2b_final: got streak=%0d total=%0d expected streak=0 total=3", last_str, last_tot);
        end
    endtask

    task automatic test_backpressure;
        logic [7:0] w[$] = '{8'hFF, 8'hFE, 8'hFF, 8'hFF, 8'h00, 8'hFF};
        run_stream(0, w, 4, 0);
    endtask

    task automatic test_saturation;
        logic [7:0] w[$];
        repeat (20) w.push_back(8'hFF);
        w.push_back(8'h0F);
        run_stream(1, w, 0, 0);
        n_checks++;
        if (peak_str !== 8'd15 || last_str !== 8'd0 || last_tot !== 8'd15) begin
            n_err++;
            $display("FAIL saturation: got peak=%0d streak=%0d total=%0d expected 15 0 15", peak_str, last_str, last_tot);
        end
    endtask

    task automatic test_clear;
        logic [7:0] w[$] = '{8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        logic [7:0] one[$] = '{8'hFF};
        run_stream(0, w, 0, 0);
        n_checks++;
        if (last_str !== 8'd5) begin
            n_err++;
            $display("FAIL clear_pre: got streak=%0d expected 5", last_str);
        end
        ib[0] = 8'hFF;
        iv[0] = 1'b1;
        ordy[0] = 1'b1;
        #1;
        tick;
        iv[0] = 1'b0;
        clr[0] = 1'b1;
        #1;
        tick;
        clr[0] = 1'b0;
        #1;
        n_checks++;
        if (ov[0] !== 1'b1 || os[0] !== 4'd8 || oh[0] !== 1'b1 || ost[0] !== 8'd1 || otot[0] !== 8'd1) begin
            n_err++;
            $display("FAIL clear_coincident: got v=%b s=%0d h=%b st=%0d tt=%0d expected 1 8 1 1 1", ov[0], os[0], oh[0], ost[0], otot[0]);
        end
        tick;
        m_str[0] = 1;
        m_tot[0] = 1;
        clr[0] = 1'b1;
        #1;
        tick;
        clr[0] = 1'b0;
        m_str[0] = 0;
        m_tot[0] = 0;
        run_stream(0, one, 0, 0);
        n_checks++;
        if (last_str !== 8'd1 || last_tot !== 8'd1) begin
            n_err++;
            $display("FAIL clear_idle: got streak=%0d total=%0d expected 1 1", last_str, last_tot);
        end
    endtask

    task automatic test_thresh;
        logic [7:0] w[$] = '{8'h1F, 8'h0F};
        run_stream(2, w, 0, 0);
        n_checks++;
        if (prev_hit !== 1'b1 || last_hit !== 1'b0) begin
            n_err++;
            $display("FAIL thresh5: got hits=%b,%b expected 1,0", prev_hit, last_hit);
        end
    endtask

    task automatic test_reset_midflight;
        ib[2] = 8'h1F;
        iv[2] = 1'b1;
        ordy[2] = 1'b0;
        #1;
        tick;
        ib[2] = 8'hFF;
        #1;
        tick;
        iv[2] = 1'b0;
        #1;
        n_checks++;
        if (ov[2] !== 1'b1 || ir[2] !== 1'b0) begin
            n_err++;
            $display("FAIL midflight_full: got out_valid=%b in_ready=%b expected 1 0", ov[2], ir[2]);
        end
        rst_n = 1'b0;
        tick;
        n_checks++;
        if (ov[2] !== 1'b0) begin
            n_err++;
            $display("FAIL midflight_reset: got out_valid=%b expected 0", ov[2]);
        end
        rst_n = 1'b1;
        ordy[2] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            m_str[k] = 0;
            m_tot[k] = 0;
        end
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++;
            if (ov[2] !== 1'b0) begin
                n_err++;
                $display("FAIL midflight_stale: got out_valid=%b expected 0 at cycle %0d", ov[2], i);
            end
            tick;
        end
    endtask

    task automatic test_random;
        logic [7:0] w[$];
        int r;
        for (int i = 0; i < 80; i++) begin
            r = $urandom_range(3);
            w.push_back(r == 0 ? 8'($urandom) : (r == 1 ? 8'hFE : 8'hFF));
        end
        run_stream(0, w, 0, 1);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            ib[k] = 8'h00;
            iv[k] = 1'b0;
            ordy[k] = 1'b1;
            clr[k] = 1'b0;
        end
        test_reset;
        test_back_to_back;
        test_backpressure;
        test_saturation;
        test_clear;
        test_thresh;
        test_reset_midflight;
        test_random;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/xnor_match_scorer.md
# xnor_match_scorer

- Sits directly downstream of the parameterised bitwise XNOR stage and consumes its `c` output, where a 1 marks a bit position in which `a` and `b` agree.
- For each accepted word, computes the number of matching bits (score) and a threshold hit flag.
- Maintains saturating counters for consecutive hits (streak) and total hits.
- Delivers results through a 2-stage valid/ready pipeline, used for pattern-match scoring in the lab comparator datapath.

## Interface
Parameters:
- WIDTH, 8, width of the XNOR word; must be ≥1.
- THRESH, WIDTH, minimum score that counts as a hit; legal range 1..WIDTH.
- CNT_W, 8, width of the streak and total-hit counters.

Ports:
- clk  in  1  sole clock; all logic is on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- eq_bits  in  WIDTH  XNOR result word; 1 means the bit matches.
- in_valid  in  1  eq_bits is valid.
- in_ready  out  1  block can accept a word this cycle.
- clear  in  1  synchronously zeroes the streak and total counters.
- out_valid  out  1  result beat is valid.
- out_ready  in  1  downstream accepts the result beat.
- score  out  SCORE_W  number of ones in the word, where SCORE_W = clog2(WIDTH+1).
- hit  out  1  score ≥ THRESH.
- streak  out  CNT_W  consecutive hits, including this beat.
- total  out  CNT_W  total hits since reset or clear, including this beat.

## Operation
- A word is accepted when in_valid && in_ready. A result is consumed when out_valid && out_ready.
- Stage S1 registers eq_bits and s1_v.
- Stage S2 is the output register. It holds score, hit, streak, total and out_valid.
- Advance rules:
  - s2_free = !out_valid || out_ready.
  - S1→S2 transfer happens when s1_v && s2_free.
  - in_ready = rst_n && (!s1_v || s2_free). This is combinational, so there are no bubbles at full rate.
- Score: popcount of the S1 word, computed combinationally between S1 and S2. Range is 0..WIDTH.
- Internal counters str_q and tot_q update only on an S1→S2 transfer:
  - On a hit: str_q ← sat(str_q+1) and tot_q ← sat(tot_q+1).
  - On a miss: str_q ← 0 and tot_q is unchanged.
  - The new values are loaded into streak and total together with the beat.
  - Saturation is at 2^CNT_W−1; the counters never wrap.
- clear:
  - Zeroes str_q and tot_q.
  - If a transfer happens in the same cycle, that beat is computed from a base of 0: streak = total = hit.
  - clear does not flush S1 or S2. A beat already sitting in S2 keeps its values.
- No combinational path from eq_bits to any output.

## Timing
- Reset (rst_n low at a clock edge): s1_v, out_valid, score, hit, streak, total and the internal counters all become 0. in_ready is 0 while rst_n is low.
- Reset mid-operation discards every in-flight beat. Discarded beats never appear on the output.
- Latency: with out_ready held high, out_valid rises 2 cycles after the accepting edge.
- Throughput: 1 word per cycle.
- Backpressure:
  - While out_valid && !out_ready, S2 holds and all output fields stay stable.
  - S1 can still fill. in_ready then falls, so at most 2 beats are buffered.
- Simultaneous consume and transfer in one cycle: S2 takes the new beat and out_valid stays 1.
- Simultaneous accept and S1 advance: S1 takes the new word.

## Structure
- Package xnor_score_pkg holds:
  - function clog2;
  - the SCORE_W derivation;
  - a sat_inc function for CNT_W counters.
- Sub-module bit_popcount:
  - Parameter WIDTH; input WIDTH bits; output SCORE_W bits.
  - Purely combinational adder tree, instantiated once between S1 and S2.

## Test plan
All scenarios use WIDTH=8, THRESH=8 unless noted.
- Reset: hold rst_n low 2 cycles with in_valid=1 → out_valid=0, in_ready=0, all fields 0. First cycle after release: in_ready=1.
- Stream 0xFF, 0xFF, 0x7F, 0xFF, 0x00 back-to-back with out_ready=1 → out_valid at accept+2, with:
  - scores 8, 8, 7, 8, 0;
  - hits 1, 1, 0, 1, 0;
  - streak 1, 2, 0, 1, 0;
  - total 1, 2, 2, 3, 3.
- Backpressure: out_ready=0 for 4 cycles with in_valid=1 → in_ready falls after 2 accepts and outputs stay stable. After release, every beat appears exactly once, in order.
- Saturation (CNT_W=4): 20 consecutive 0xFF → streak and total reach 15 and stay at 15. Then 0x0F → streak 0, total 15.
- Clear coincidence: after streak=5, assert clear in the cycle a 0xFF beat moves into S2 → that beat shows streak 1, total 1.
- THRESH=5: words 0x1F, 0x0F → hits 1, 0. Separately, reset asserted with S1 and S2 full → out_valid=0 on the next cycle and stale beats never appear.
